// File: rtl/execute_stage_pipelined_if.sv
// ID/EX operand bus and EX/MEM result slot of the pipelined execute stage.
// The stage itself connects through the slave modport; the producer/consumer side uses master.
interface execute_stage_pipelined_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     alu_read_data_1;
  logic [DATA_W-1:0]     alu_read_data_2;
  logic [DATA_W-1:0]     immediate;
  logic [5:0]            funct;
  logic [2:0]            alu_op;
  logic                  alu_src;
  logic                  reg_dst;
  logic [DATA_W-1:0]     pc;
  logic [REG_ADDR_W-1:0] rt;
  logic [REG_ADDR_W-1:0] rd;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     alu_result;
  logic                  zero;
  logic [DATA_W-1:0]     add_result;
  logic [DATA_W-1:0]     read_data_2_out;
  logic [REG_ADDR_W-1:0] rd_or_rt;
  logic                  busy;

  modport master (
    output in_valid, alu_read_data_1, alu_read_data_2, immediate, funct, alu_op,
           alu_src, reg_dst, pc, rt, rd, out_ready,
    input  in_ready, out_valid, alu_result, zero, add_result, read_data_2_out,
           rd_or_rt, busy
  );

  modport slave (
    input  in_valid, alu_read_data_1, alu_read_data_2, immediate, funct, alu_op,
           alu_src, reg_dst, pc, rt, rd, out_ready,
    output in_ready, out_valid, alu_result, zero, add_result, read_data_2_out,
           rd_or_rt, busy
  );
endinterface

// File: rtl/execute_stage_pipelined.sv
// Registered execute stage: ALU, branch-target add and destination select into an
// EX/MEM slot, plus an iterative multiply/divide unit with HI/LO that stalls ID/EX.
module execute_stage_pipelined #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int SHAMT_W    = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  execute_stage_pipelined_if.slave ex
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MULDIV = 1'b1} state_t;

  state_t                  state_r, state_nxt_s;
  logic                    in_ready_s, accept_s, is_muldiv_s, md_start_s, md_last_s;
  logic                    md_signed_s, slt_s, sltu_s;
  logic [DATA_W-1:0]       op_b_s, alu_res_s, rtype_s, add_res_s, a_mag_s, b_mag_s;
  logic [SHAMT_W-1:0]      shamt_s;

  logic                    out_valid_r, zero_r;
  logic [DATA_W-1:0]       alu_result_r, add_result_r, read_data_2_r;
  logic [REG_ADDR_W-1:0]   rd_or_rt_r;

  logic [DATA_W-1:0]       hi_r, lo_r, opnd_r, md_dividend_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [2*DATA_W-1:0]     acc_r, acc_nxt_s, prod_s;
  logic                    md_is_div_r, md_neg_q_r, md_neg_r_r, md_div0_r;
  logic [DATA_W:0]         mul_sum_s, div_shift_s, div_diff_s;
  logic [DATA_W-1:0]       hi_fin_s, lo_fin_s;

  assign op_b_s      = ex.alu_src ? ex.immediate : ex.alu_read_data_2;
  assign shamt_s     = ex.immediate[6 +: SHAMT_W];
  assign add_res_s   = ex.pc + {ex.immediate[DATA_W-3:0], 2'b00};
  assign slt_s       = $signed(ex.alu_read_data_1) < $signed(op_b_s);
  assign sltu_s      = ex.alu_read_data_1 < op_b_s;
  // funct 0x18..0x1B: mult, multu, div, divu
  assign is_muldiv_s = (ex.alu_op == 3'b010) && (ex.funct[5:2] == 4'b0110);
  assign in_ready_s  = rst_n && (state_r == ST_IDLE) && (!out_valid_r || ex.out_ready);
  assign accept_s    = ex.in_valid && in_ready_s;
  assign md_start_s  = accept_s && is_muldiv_s;
  assign md_last_s   = (state_r == ST_MULDIV) && (cnt_r == LAST_ITER);

  // R-type function decode
  always_comb begin
    rtype_s = '0;
    case (ex.funct)
      6'h20, 6'h21: rtype_s = ex.alu_read_data_1 + op_b_s;
      6'h22, 6'h23: rtype_s = ex.alu_read_data_1 - op_b_s;
      6'h24:        rtype_s = ex.alu_read_data_1 & op_b_s;
      6'h25:        rtype_s = ex.alu_read_data_1 | op_b_s;
      6'h26:        rtype_s = ex.alu_read_data_1 ^ op_b_s;
      6'h27:        rtype_s = ~(ex.alu_read_data_1 | op_b_s);
      6'h2A:        rtype_s = {{(DATA_W-1){1'b0}}, slt_s};
      6'h2B:        rtype_s = {{(DATA_W-1){1'b0}}, sltu_s};
      6'h00:        rtype_s = op_b_s << shamt_s;
      6'h02:        rtype_s = op_b_s >> shamt_s;
      6'h03:        rtype_s = $signed(op_b_s) >>> shamt_s;
      6'h10:        rtype_s = hi_r;
      6'h12:        rtype_s = lo_r;
      default:      rtype_s = '0;
    endcase
  end

  // Main-decoder ALU class; unused encodings behave as add
  always_comb begin
    alu_res_s = '0;
    case (ex.alu_op)
      3'b001:  alu_res_s = ex.alu_read_data_1 - op_b_s;
      3'b011:  alu_res_s = ex.alu_read_data_1 & op_b_s;
      3'b100:  alu_res_s = ex.alu_read_data_1 | op_b_s;
      3'b101:  alu_res_s = {{(DATA_W-1){1'b0}}, slt_s};
      3'b010:  alu_res_s = rtype_s;
      default: alu_res_s = ex.alu_read_data_1 + op_b_s;
    endcase
  end

  // EX/MEM output slot; multiply/divide never fills it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r   <= 1'b0;
      alu_result_r  <= '0;
      zero_r        <= 1'b0;
      add_result_r  <= '0;
      read_data_2_r <= '0;
      rd_or_rt_r    <= '0;
    end else if (accept_s && !is_muldiv_s) begin
      out_valid_r   <= 1'b1;
      alu_result_r  <= alu_res_s;
      zero_r        <= (alu_res_s == '0);
      add_result_r  <= add_res_s;
      read_data_2_r <= ex.alu_read_data_2;
      rd_or_rt_r    <= ex.reg_dst ? ex.rd : ex.rt;
    end else if (ex.out_ready) begin
      out_valid_r   <= 1'b0;
    end
  end

  // Operands are iterated as magnitudes; signs are reapplied on the final cycle
  assign md_signed_s = !ex.funct[0];
  assign a_mag_s = (md_signed_s && ex.alu_read_data_1[DATA_W-1]) ? -ex.alu_read_data_1 : ex.alu_read_data_1;
  assign b_mag_s = (md_signed_s && op_b_s[DATA_W-1]) ? -op_b_s : op_b_s;

  assign mul_sum_s   = {1'b0, acc_r[2*DATA_W-1:DATA_W]} + (acc_r[0] ? {1'b0, opnd_r} : '0);
  assign div_shift_s = {acc_r[2*DATA_W-1:DATA_W], acc_r[DATA_W-1]};
  assign div_diff_s  = div_shift_s - {1'b0, opnd_r};

  // One shift-add or restoring-divide step; acc holds {hi/remainder, lo/quotient}
  always_comb begin
    acc_nxt_s = acc_r;
    if (md_is_div_r) begin
      if (!div_diff_s[DATA_W]) begin
        acc_nxt_s = {div_diff_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b1};
      end else begin
        acc_nxt_s = {div_shift_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b0};
      end
    end else begin
      acc_nxt_s = {mul_sum_s, acc_r[DATA_W-1:1]};
    end
  end

  // Sign fix-up and divide-by-zero result for the HI/LO write
  always_comb begin
    prod_s   = md_neg_q_r ? -acc_nxt_s : acc_nxt_s;
    hi_fin_s = prod_s[2*DATA_W-1:DATA_W];
    lo_fin_s = prod_s[DATA_W-1:0];
    if (md_is_div_r) begin
      if (md_div0_r) begin
        lo_fin_s = '1;
        hi_fin_s = md_dividend_r;
      end else begin
        lo_fin_s = md_neg_q_r ? -acc_nxt_s[DATA_W-1:0] : acc_nxt_s[DATA_W-1:0];
        hi_fin_s = md_neg_r_r ? -acc_nxt_s[2*DATA_W-1:DATA_W] : acc_nxt_s[2*DATA_W-1:DATA_W];
      end
    end else begin
      hi_fin_s = prod_s[2*DATA_W-1:DATA_W];
      lo_fin_s = prod_s[DATA_W-1:0];
    end
  end

  // Multiply/divide operand latch, iteration and HI/LO write-back
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r         <= '0;
      acc_r         <= '0;
      opnd_r        <= '0;
      md_dividend_r <= '0;
      md_is_div_r   <= 1'b0;
      md_neg_q_r    <= 1'b0;
      md_neg_r_r    <= 1'b0;
      md_div0_r     <= 1'b0;
      hi_r          <= '0;
      lo_r          <= '0;
    end else if (md_start_s) begin
      cnt_r         <= '0;
      acc_r         <= {{DATA_W{1'b0}}, a_mag_s};
      opnd_r        <= b_mag_s;
      md_dividend_r <= ex.alu_read_data_1;
      md_is_div_r   <= ex.funct[1];
      md_neg_q_r    <= md_signed_s && (ex.alu_read_data_1[DATA_W-1] ^ op_b_s[DATA_W-1]);
      md_neg_r_r    <= md_signed_s && ex.alu_read_data_1[DATA_W-1];
      md_div0_r     <= (op_b_s == '0);
    end else if (state_r == ST_MULDIV) begin
      cnt_r <= cnt_r + CNT_W'(1);
      acc_r <= acc_nxt_s;
      if (md_last_s) begin
        hi_r <= hi_fin_s;
        lo_r <= lo_fin_s;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (md_start_s) state_nxt_s = ST_MULDIV;
        else            state_nxt_s = ST_IDLE;
      end
      ST_MULDIV: begin
        if (md_last_s) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_MULDIV;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  assign ex.in_ready        = in_ready_s;
  assign ex.out_valid       = out_valid_r;
  assign ex.alu_result      = alu_result_r;
  assign ex.zero            = zero_r;
  assign ex.add_result      = add_result_r;
  assign ex.read_data_2_out = read_data_2_r;
  assign ex.rd_or_rt        = rd_or_rt_r;
  assign ex.busy            = (state_r == ST_MULDIV);
endmodule

// File: tb/tb_execute_stage_pipelined.sv
// Scoreboard bench for execute_stage_pipelined: directed corner cases then random ops
// against a plain-arithmetic reference model; a monitor pops expected beats on each transfer.
module tb_execute_stage_pipelined;
  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [4:0]  dst;
  } exp_t;

  typedef struct {
    logic [31:0] a, b, imm, pc;
    logic [5:0]  funct;
    logic [2:0]  op;
    logic        src, rdst;
    logic [4:0]  rt, rd;
  } op_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  execute_stage_pipelined_if #(.DATA_W(DW), .REG_ADDR_W(AW)) bus ();
  execute_stage_pipelined #(.DATA_W(DW), .REG_ADDR_W(AW), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .ex(bus.slave)
  );

  int tests = 0;
  int fails = 0;
  exp_t sb[$];
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;
  int rdy_mode = 0;
  logic [5:0] funct_tbl [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h10, 6'h12, 6'h01, 6'h3F};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic op_t mk(input logic [2:0] op, input logic [5:0] fn, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc,
                             input logic src, input logic rdst, input logic [4:0] rt, input logic [4:0] rd);
    op_t o;
    o.op = op; o.funct = fn; o.a = a; o.b = b; o.imm = imm; o.pc = pc;
    o.src = src; o.rdst = rdst; o.rt = rt; o.rd = rd;
    return o;
  endfunction

  function automatic logic [31:0] opb(input op_t o);
    return o.src ? o.imm : o.b;
  endfunction

  function automatic bit is_md(input op_t o);
    return (o.op == 3'd2) && (o.funct inside {6'h18, 6'h19, 6'h1A, 6'h1B});
  endfunction

  // Reference ALU from the operation table, using plain integer arithmetic
  function automatic logic [31:0] ref_alu(input op_t o);
    logic [31:0] b;
    logic signed [31:0] sbv;
    int sh;
    b = opb(o);
    sbv = b;
    sh = int'(o.imm[10:6]);
    if (o.op == 3'd1) return o.a - b;
    if (o.op == 3'd3) return o.a & b;
    if (o.op == 3'd4) return o.a | b;
    if (o.op == 3'd5) return (int'(o.a) < int'(b)) ? 32'd1 : 32'd0;
    if (o.op != 3'd2) return o.a + b;
    case (o.funct)
      6'h20, 6'h21: return o.a + b;
      6'h22, 6'h23: return o.a - b;
      6'h24: return o.a & b;
      6'h25: return o.a | b;
      6'h26: return o.a ^ b;
      6'h27: return ~(o.a | b);
      6'h2A: return (int'(o.a) < int'(b)) ? 32'd1 : 32'd0;
      6'h2B: return (longint'({32'h0, o.a}) < longint'({32'h0, b})) ? 32'd1 : 32'd0;
      6'h00: return b << sh;
      6'h02: return b >> sh;
      6'h03: return sbv >>> sh;
      6'h10: return m_hi;
      6'h12: return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_md(input op_t o);
    logic [31:0] b;
    longint p, sa, sbl, q, r;
    b = opb(o);
    sa = longint'($signed(o.a));
    sbl = longint'($signed(b));
    case (o.funct)
      6'h18: begin p = sa * sbl; m_hi = p[63:32]; m_lo = p[31:0]; end
      6'h19: begin p = longint'({32'h0, o.a}) * longint'({32'h0, b}); m_hi = p[63:32]; m_lo = p[31:0]; end
      6'h1A: begin
        if (b == 32'h0) begin m_lo = 32'hFFFFFFFF; m_hi = o.a; end
        else begin q = sa / sbl; r = sa % sbl; m_lo = q[31:0]; m_hi = r[31:0]; end
      end
      default: begin
        if (b == 32'h0) begin m_lo = 32'hFFFFFFFF; m_hi = o.a; end
        else begin m_lo = o.a / b; m_hi = o.a % b; end
      end
    endcase
  endtask

  function automatic exp_t expect_of(input op_t o);
    exp_t e;
    e.res = ref_alu(o);
    e.z = (e.res == 32'h0);
    e.addr = o.pc + {o.imm[29:0], 2'b00};
    e.sd = o.b;
    e.dst = o.rdst ? o.rd : o.rt;
    return e;
  endfunction

  // Drive one op; returns at posedge+1 after the accepting edge
  task automatic issue(input op_t o);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.alu_read_data_1 = o.a; bus.alu_read_data_2 = o.b; bus.immediate = o.imm;
    bus.funct = o.funct; bus.alu_op = o.op; bus.alu_src = o.src; bus.reg_dst = o.rdst;
    bus.pc = o.pc; bus.rt = o.rt; bus.rd = o.rd;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL issue_timeout: in_ready never rose for funct %0h", o.funct);
      bus.in_valid = 1'b0;
    end else begin
      if (is_md(o)) model_md(o);
      else sb.push_back(expect_of(o));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Output-ready driver
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard pop on transfer, stability while stalled
  initial begin
    exp_t cur, held, e;
    bit hold_v;
    hold_v = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin hold_v = 1'b0; continue; end
      cur.res = bus.alu_result; cur.z = bus.zero; cur.addr = bus.add_result;
      cur.sd = bus.read_data_2_out; cur.dst = bus.rd_or_rt;
      if (hold_v) check("hold_stable", {bus.out_valid, cur}, {1'b1, held});
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          e = sb.pop_front();
          check("beat", cur, e);
        end
      end
      hold_v = bus.out_valid && !bus.out_ready;
      held = cur;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t o;
    int nb, nr;
    rst_n = 1'b0;
    o = mk(3'd0, 6'h20, 32'h1234, 32'h5678, 32'h9, 32'h100, 1'b0, 1'b1, 5'd1, 5'd2);
    bus.in_valid = 1'b1;
    bus.alu_read_data_1 = o.a; bus.alu_read_data_2 = o.b; bus.immediate = o.imm;
    bus.funct = o.funct; bus.alu_op = o.op; bus.alu_src = o.src; bus.reg_dst = o.rdst;
    bus.pc = o.pc; bus.rt = o.rt; bus.rd = o.rd;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_in_ready", bus.in_ready, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_outputs", {bus.alu_result, bus.zero, bus.add_result, bus.read_data_2_out, bus.rd_or_rt}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("release_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;

    issue(mk(3'd2, 6'h20, 32'h5, 32'hFFFFFFFB, 32'h0, 32'h0, 1'b0, 1'b1, 5'd3, 5'd7));
    check("radd_valid", bus.out_valid, 1);
    check("radd_result", {bus.alu_result, bus.zero, bus.rd_or_rt}, {32'h0, 1'b1, 5'd7});

    issue(mk(3'd0, 6'h00, 32'h100, 32'hABCD, 32'h10, 32'h400, 1'b1, 1'b0, 5'd4, 5'd9));
    check("imm_add", {bus.alu_result, bus.add_result}, {32'h110, 32'h440});

    issue(mk(3'd2, 6'h03, 32'h0, 32'h80000000, 32'h100, 32'h0, 1'b0, 1'b1, 5'd4, 5'd9));
    check("sra", bus.alu_result, 32'hF8000000);

    repeat (3) @(posedge clk);
    rdy_mode = 2;
    #2;
    fork
      begin
        issue(mk(3'd0, 6'h00, 32'h11, 32'h1, 32'h1, 32'h0, 1'b0, 1'b0, 5'd1, 5'd2));
        issue(mk(3'd1, 6'h00, 32'h22, 32'h2, 32'h1, 32'h4, 1'b0, 1'b1, 5'd3, 5'd4));
        issue(mk(3'd4, 6'h00, 32'h30, 32'h3, 32'h1, 32'h8, 1'b0, 1'b0, 5'd5, 5'd6));
      end
      begin
        repeat (6) @(negedge clk);
        check("bp_in_ready_low", bus.in_ready, 0);
        check("bp_out_valid", bus.out_valid, 1);
        rdy_mode = 0;
      end
    join
    repeat (3) @(posedge clk); #1;

    issue(mk(3'd2, 6'h18, 32'hFFFFFFFD, 32'h7, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0));
    nb = 0; nr = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.busy) nb++;
      if (!bus.in_ready) nr++;
      if (!bus.busy && bus.in_ready) break;
    end
    check("mult_busy_cycles", nb, 32);
    check("mult_in_ready_low", nr, 32);
    @(posedge clk); #1;
    issue(mk(3'd2, 6'h12, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd0, 5'd8));
    check("mult_mflo", bus.alu_result, 32'hFFFFFFEB);
    issue(mk(3'd2, 6'h10, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd0, 5'd8));
    check("mult_mfhi", bus.alu_result, 32'hFFFFFFFF);

    issue(mk(3'd2, 6'h1A, 32'hFFFFFFF9, 32'h2, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0));
    issue(mk(3'd2, 6'h12, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd0, 5'd8));
    check("div_mflo", bus.alu_result, 32'hFFFFFFFD);
    issue(mk(3'd2, 6'h10, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd0, 5'd8));
    check("div_mfhi", bus.alu_result, 32'hFFFFFFFF);

    issue(mk(3'd2, 6'h1B, 32'h9, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0));
    issue(mk(3'd2, 6'h12, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd0, 5'd8));
    check("divu0_mflo", bus.alu_result, 32'hFFFFFFFF);
    issue(mk(3'd2, 6'h10, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd0, 5'd8));
    check("divu0_mfhi", bus.alu_result, 32'h9);

    issue(mk(3'd2, 6'h1A, 32'h12345, 32'h77, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0));
    repeat (9) @(posedge clk);
    #1;
    check("busy_before_abort", bus.busy, 1);
    rst_n = 1'b0;
    m_hi = 32'h0; m_lo = 32'h0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_busy", bus.busy, 0);
    @(posedge clk); #1;
    issue(mk(3'd2, 6'h10, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd0, 5'd8));
    check("abort_hi", bus.alu_result, 32'h0);
    issue(mk(3'd2, 6'h12, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd0, 5'd8));
    check("abort_lo", bus.alu_result, 32'h0);

    rdy_mode = 1;
    for (int k = 0; k < 400; k++) begin
      o = mk(3'($urandom_range(0, 7)), funct_tbl[$urandom_range(0, 16)], rnd_val(), rnd_val(),
             rnd_val(), $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 19) == 0) begin
        o.op = 3'd2;
        o.funct = 6'h18 + 6'($urandom_range(0, 3));
      end
      issue(o);
    end
    rdy_mode = 0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
